// File: rtl/commit_trace_buf_pkg.sv
// commit_pkg: shared commit entry type and default trap word for the commit trace buffer
package commit_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } commit_entry_t;
  localparam logic [31:0] TRAP_INSTR_DEFAULT = 32'h8000_0000;
endpackage

// File: rtl/commit_trace_buf_if.sv
// commit_trace_buf_if: dual-slot commit port; master presents entries, slave answers ready
interface commit_trace_buf_if;
  import commit_pkg::*;
  logic          valid_1;
  logic          valid_2;
  commit_entry_t entry_1;
  commit_entry_t entry_2;
  logic          ready;
  modport master (output valid_1, valid_2, entry_1, entry_2, input ready);
  modport slave (input valid_1, valid_2, entry_1, entry_2, output ready);
endinterface

// File: rtl/commit_trace_buf_fifo_mem.sv
// commit_fifo_mem: DEPTH-entry commit storage, two indexed write ports, two async read ports
module commit_fifo_mem
  import commit_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          we_1,
  input  logic          we_2,
  input  logic [AW-1:0] wa_1,
  input  logic [AW-1:0] wa_2,
  input  commit_entry_t wd_1,
  input  commit_entry_t wd_2,
  input  logic [AW-1:0] ra_1,
  input  logic [AW-1:0] ra_2,
  output commit_entry_t rd_1,
  output commit_entry_t rd_2
);
  commit_entry_t mem [DEPTH];
  // cleared on reset so idle output fields read as zero
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (we_1) mem[wa_1] <= wd_1;
      if (we_2) mem[wa_2] <= wd_2;
    end
  assign rd_1 = mem[ra_1];
  assign rd_2 = mem[ra_2];
endmodule

// File: rtl/commit_trace_buf.sv
// commit_trace_buf: dual-issue in-order commit FIFO with cycle/instr counters and trap latch
// Trap detection, single-pop-on-trap and post-trap freeze are enabled by COMMIT_TRAP_EN.
module commit_trace_buf
  import commit_pkg::*;
#(
  parameter int          DEPTH      = 8,
  parameter logic [31:0] TRAP_INSTR = TRAP_INSTR_DEFAULT,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  commit_trace_buf_if.slave  in_port,
  commit_trace_buf_if.master out_port,
  output logic [63:0]        cycle_cnt,
  output logic [63:0]        instr_cnt,
  output logic               overflow,
  output logic               trap_valid,
  output logic [7:0]         trap_code,
  output logic [31:0]        trap_pc
);
`ifdef COMMIT_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - 2);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    pushes, pops;
  logic          attempt, accept, trap_1;
  commit_entry_t rd_1, rd_2;
  assign in_port.ready = count <= READY_MAX;
  assign attempt = in_port.valid_1 | in_port.valid_2;
  assign accept = attempt & in_port.ready;
  assign pushes = accept ? {1'b0, in_port.valid_1} + {1'b0, in_port.valid_2} : 2'd0;
  assign out_port.valid_1 = (count != '0) && !trap_valid;
  assign out_port.valid_2 = (count > (AW+1)'(1)) && !trap_valid;
  assign out_port.entry_1 = rd_1;
  assign out_port.entry_2 = rd_2;
  assign trap_1 = TRAP_EN && (rd_1.instr == TRAP_INSTR);
  // a trap at the head drains alone so nothing younger is retired past it
  assign pops = !out_port.ready ? 2'd0 :
                (out_port.valid_1 && trap_1) ? 2'd1 :
                {1'b0, out_port.valid_1} + {1'b0, out_port.valid_2};
  commit_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clock   (clock),
    .reset_n (reset_n),
    .we_1    (accept),
    .we_2    (accept & in_port.valid_1 & in_port.valid_2),
    .wa_1    (wr_ptr),
    .wa_2    (wr_ptr + AW'(1)),
    .wd_1    (in_port.valid_1 ? in_port.entry_1 : in_port.entry_2),
    .wd_2    (in_port.entry_2),
    .ra_1    (rd_ptr),
    .ra_2    (rd_ptr + AW'(1)),
    .rd_1    (rd_1),
    .rd_2    (rd_2)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + AW'(pushes);
      rd_ptr    <= rd_ptr + AW'(pops);
      count     <= count + (AW+1)'(pushes) - (AW+1)'(pops);
      cycle_cnt <= cycle_cnt + 64'd1;
      instr_cnt <= instr_cnt + 64'(pops);
      overflow  <= overflow | (attempt & ~in_port.ready);
    end
`ifdef COMMIT_TRAP_EN
  logic trap_2, trap_hit;
  assign trap_2 = rd_2.instr == TRAP_INSTR;
  assign trap_hit = ((pops != 2'd0) && trap_1) || ((pops == 2'd2) && trap_2);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      trap_valid <= 1'b0;
      trap_code  <= '0;
      trap_pc    <= '0;
    end else if (trap_hit && !trap_valid) begin
      trap_valid <= 1'b1;
      trap_code  <= trap_1 ? rd_1.wdata[7:0] : rd_2.wdata[7:0];
      trap_pc    <= trap_1 ? rd_1.pc : rd_2.pc;
    end
`else
  assign trap_valid = 1'b0;
  assign trap_code  = '0;
  assign trap_pc    = '0;
`endif
endmodule
